shift_arbiter: RTL

- Shares one combinational `barrel_shifter` (4-bit rotate-left datapath) between two independent requesters, A and B.
- Arbitration is round-robin over valid/ready request channels.
- The shifted result goes into a single-entry output register, tagged with the requester ID.
- Sits between the pin-level wrapper logic and the shifter; it is the only path by which multiple sources reach the shifter.

---
 rtl/shift_pkg.sv | 14 +
 rtl/barrel_shifter.sv | 14 +
 rtl/shift_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared constants for the shift arbiter slice: datapath widths, requester IDs
// and the output-register state encoding.
package shift_pkg;

  localparam int DATA_W = 4;
  localparam int AMT_W  = 2;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational rotate-left: o[k] = i[(k - s) mod DATA_W]; s = 0 passes i through.
module barrel_shifter #(
  parameter int DATA_W = shift_pkg::DATA_W,
  parameter int AMT_W  = shift_pkg::AMT_W
) (
  input  logic [DATA_W-1:0] i,
  input  logic [AMT_W-1:0]  s,
  output logic [DATA_W-1:0] o
);

  // With s = 0 the right shift moves every bit out, leaving a clean pass-through.
  assign o = (i << s) | (i >> (DATA_W - int'(s)));

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel_shifter between requesters A and B,
// with a single-entry tagged result register and a consumed-result counter.
module shift_arbiter #(
  parameter int DATA_W = shift_pkg::DATA_W,
  parameter int AMT_W  = shift_pkg::AMT_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic [AMT_W-1:0]  a_amt,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic [AMT_W-1:0]  b_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id,
  output logic [CNT_W-1:0]  done_cnt
);

  import shift_pkg::*;

  logic [0:0]        state;
  logic              last_id;
  logic              can_accept;
  logic              grant_valid;
  logic              grant_id;
  logic              accept;
  logic              consume;
  logic [DATA_W-1:0] sel_data;
  logic [AMT_W-1:0]  sel_amt;
  logic [DATA_W-1:0] rot_data;

  assign out_valid  = (state == ST_FULL);
  assign can_accept = !out_valid || out_ready;
  assign consume    = out_valid && out_ready;

  // Under contention the requester that was not served last wins.
  always_comb begin
    grant_valid = a_valid || b_valid;
    grant_id    = ID_A;
    if (a_valid && b_valid) begin
      grant_id = ~last_id;
    end else if (b_valid) begin
      grant_id = ID_B;
    end
  end

  assign accept  = !rst && can_accept && grant_valid;
  assign a_ready = accept && (grant_id == ID_A);
  assign b_ready = accept && (grant_id == ID_B);

  always_comb begin
    sel_data = a_data;
    sel_amt  = a_amt;
    if (grant_id == ID_B) begin
      sel_data = b_data;
      sel_amt  = b_amt;
    end
  end

  barrel_shifter #(
    .DATA_W (DATA_W),
    .AMT_W  (AMT_W)
  ) u_shifter (
    .i (sel_data),
    .s (sel_amt),
    .o (rot_data)
  );

  // A new accept overwrites the register even when the old result is being
  // consumed in the same cycle, which keeps throughput at one per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_id   <= ID_A;
      last_id  <= ID_B;
      done_cnt <= '0;
    end else begin
      if (consume) begin
        done_cnt <= done_cnt + CNT_W'(1);
      end
      if (accept) begin
        state    <= ST_FULL;
        out_data <= rot_data;
        out_id   <= grant_id;
        last_id  <= grant_id;
      end else if (consume) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule
